solver: RTL and testbench

SOLVER -- requirements
Module: solver

---
 rtl/solver.sv | 92 +++++++++
 tb/tb_solver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/solver.sv
// solver: Mandelbrot escape-time iterator on multi-limb two's-complement fixed point.
module solver #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS = 8,
    parameter int DIVERGENCE_RADIUS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_real_en,
    input  logic                       wr_imag_en,
    input  logic [LIMB_INDEX_BITS-1:0] wr_index,
    input  logic [LIMB_SIZE_BITS-1:0]  real_data,
    input  logic [LIMB_SIZE_BITS-1:0]  imag_data,
    input  logic                       wr_num_limbs_en,
    input  logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    input  logic                       wr_iter_lim_en,
    input  logic [15:0]                iter_lim_data,
    input  logic                       start,
    output logic                       out_ready,
    output logic [15:0]                iterations
);
    localparam int MAXL = 2 ** LIMB_INDEX_BITS;
    localparam int L = LIMB_SIZE_BITS;
    localparam int W = MAXL * L;
    localparam int F = W - L;
    localparam logic [2*W+1:0] THRESH = (2*W+2)'(DIVERGENCE_RADIUS) << (2 * F);

    typedef enum logic {IDLE, ITER} state_t;
    state_t state;

    logic [W-1:0] c_re, c_im;
    logic signed [W-1:0] z_re, z_im;
    logic [LIMB_INDEX_BITS-1:0] num_limbs;
    logic [15:0] iter_lim, count;

    logic [LIMB_INDEX_BITS:0] n_eff;
    logic [W-1:0] mask;
    logic signed [2*W-1:0] re2, im2, reim;
    logic [2*W+1:0] mag;
    logic [W-1:0] re2_t, im2_t, xy2_t, nz_re, nz_im;
    logic done;

    // Keeping only the top n_eff limbs both zeroes inactive c limbs and truncates z toward -inf.
    assign n_eff = (num_limbs == '0) ? (LIMB_INDEX_BITS+1)'(1) : {1'b0, num_limbs};
    assign mask  = ~({W{1'b1}} >> (n_eff * L));
    assign re2   = z_re * z_re;
    assign im2   = z_im * z_im;
    assign reim  = z_re * z_im;
    assign mag   = {2'b00, re2} + {2'b00, im2};
    assign re2_t = W'(re2 >>> F);
    assign im2_t = W'(im2 >>> F);
    // Doubling folds into the shift: floor(2*p / 2^F) == floor(p / 2^(F-1)).
    assign xy2_t = W'(reim >>> (F - 1));
    assign nz_re = (re2_t - im2_t + (c_re & mask)) & mask;
    assign nz_im = (xy2_t + (c_im & mask)) & mask;
    assign done  = (mag > THRESH) || (count == iter_lim);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            out_ready  <= 1'b0;
            iterations <= '0;
            c_re       <= '0;
            c_im       <= '0;
            num_limbs  <= LIMB_INDEX_BITS'(1);
            iter_lim   <= '0;
            z_re       <= '0;
            z_im       <= '0;
            count      <= '0;
        end else if (state == IDLE) begin
            if (wr_real_en) c_re[W-1-int'(wr_index)*L -: L] <= real_data;
            if (wr_imag_en) c_im[W-1-int'(wr_index)*L -: L] <= imag_data;
            if (wr_num_limbs_en) num_limbs <= num_limbs_data;
            if (wr_iter_lim_en) iter_lim <= iter_lim_data;
            if (start) begin
                z_re      <= '0;
                z_im      <= '0;
                count     <= '0;
                out_ready <= 1'b0;
                state     <= ITER;
            end
        end else if (done) begin
            iterations <= count;
            out_ready  <= 1'b1;
            state      <= IDLE;
        end else begin
            z_re  <= nz_re;
            z_im  <= nz_im;
            count <= count + 16'd1;
        end
    end
endmodule

// File: tb/tb_solver.sv
// tb_solver: directed self-checking bench for the solver escape-time iterator.
module tb_solver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic wr_real_en = 1'b0, wr_imag_en = 1'b0;
    logic [5:0] wr_index = '0;
    logic [7:0] real_data = '0, imag_data = '0;
    logic wr_num_limbs_en = 1'b0;
    logic [5:0] num_limbs_data = '0;
    logic wr_iter_lim_en = 1'b0;
    logic [15:0] iter_lim_data = '0;
    logic start = 1'b0;
    logic out_ready;
    logic [15:0] iterations;

    int compared = 0;
    int mismatched = 0;
    localparam int LIMIT = 200;

    solver dut (
        .clock(clock), .reset(reset),
        .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_index(wr_index),
        .real_data(real_data), .imag_data(imag_data),
        .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
        .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
        .start(start), .out_ready(out_ready), .iterations(iterations)
    );

    always #5 clock = ~clock;

    task automatic wr_c(input int idx, input logic [7:0] re, input logic [7:0] im);
        @(negedge clock);
        wr_index = 6'(idx); real_data = re; imag_data = im;
        wr_real_en = 1'b1; wr_imag_en = 1'b1;
        @(posedge clock); #1;
        wr_real_en = 1'b0; wr_imag_en = 1'b0;
    endtask

    task automatic cfg(input int n, input int lim);
        @(negedge clock);
        num_limbs_data = 6'(n); iter_lim_data = 16'(lim);
        wr_num_limbs_en = 1'b1; wr_iter_lim_en = 1'b1;
        @(posedge clock); #1;
        wr_num_limbs_en = 1'b0; wr_iter_lim_en = 1'b0;
    endtask

    task automatic kick();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // lat counts edges since the start edge until out_ready is seen high.
    task automatic wait_ready(inout int lat);
        while (!out_ready && lat < LIMIT) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic run(output int lat, output logic [15:0] it);
        kick();
        lat = 0;
        wait_ready(lat);
        it = iterations;
    endtask

    task automatic test_reset();
        int lat; logic [15:0] it;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        compared++;
        if (out_ready !== 1'b0) begin mismatched++; $display("FAIL reset_out_ready got %b want 0", out_ready); end
        compared++;
        if (iterations !== 16'd0) begin mismatched++; $display("FAIL reset_iterations got %0d want 0", iterations); end
        run(lat, it);
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL reset_default_latency got %0d want 1", lat); end
        compared++;
        if (it !== 16'd0) begin mismatched++; $display("FAIL reset_default_iterations got %0d want 0", it); end
    endtask

    task automatic test_iter_zero();
        int lat; logic [15:0] it;
        cfg(2, 0);
        wr_c(0, 8'h01, 8'h01);
        wr_c(1, 8'h00, 8'h00);
        run(lat, it);
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL iter_zero_latency got %0d want 1", lat); end
        compared++;
        if (it !== 16'd0) begin mismatched++; $display("FAIL iter_zero_iterations got %0d want 0", it); end
    endtask

    task automatic test_basic();
        int lat; logic [15:0] it;
        cfg(2, 10);
        wr_c(0, 8'h01, 8'h01);
        wr_c(1, 8'h00, 8'h00);
        run(lat, it);
        compared++;
        if (lat !== 3) begin mismatched++; $display("FAIL basic_latency got %0d want 3", lat); end
        compared++;
        if (it !== 16'd2) begin mismatched++; $display("FAIL basic_iterations got %0d want 2", it); end
        repeat (5) @(posedge clock);
        #1;
        compared++;
        if (out_ready !== 1'b1) begin mismatched++; $display("FAIL basic_hold_ready got %b want 1", out_ready); end
        compared++;
        if (iterations !== 16'd2) begin mismatched++; $display("FAIL basic_hold_iterations got %0d want 2", iterations); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] it;
        for (int r = 0; r < 4; r++) begin
            run(lat, it);
            compared++;
            if (lat !== 3) begin mismatched++; $display("FAIL b2b_latency run %0d got %0d want 3", r, lat); end
            compared++;
            if (it !== 16'd2) begin mismatched++; $display("FAIL b2b_iterations run %0d got %0d want 2", r, it); end
        end
    endtask

    task automatic test_zero_c();
        int lat; logic [15:0] it;
        cfg(2, 10);
        wr_c(0, 8'h00, 8'h00);
        wr_c(1, 8'h00, 8'h00);
        run(lat, it);
        compared++;
        if (lat !== 11) begin mismatched++; $display("FAIL zero_c_latency got %0d want 11", lat); end
        compared++;
        if (it !== 16'd10) begin mismatched++; $display("FAIL zero_c_iterations got %0d want 10", it); end
    endtask

    task automatic test_bounded();
        int lat; logic [15:0] it;
        cfg(2, 20);
        wr_c(0, 8'hFF, 8'h00);
        wr_c(1, 8'hC0, 8'h00);
        run(lat, it);
        compared++;
        if (lat !== 21) begin mismatched++; $display("FAIL bounded_latency got %0d want 21", lat); end
        compared++;
        if (it !== 16'd20) begin mismatched++; $display("FAIL bounded_iterations got %0d want 20", it); end
    endtask

    // c = 1.5 at two limbs escapes after 2; truncated to one limb c = 1 hits |z|^2 == 4 exactly and escapes after 3.
    task automatic test_precision();
        int lat; logic [15:0] it;
        wr_c(0, 8'h01, 8'h00);
        wr_c(1, 8'h80, 8'h00);
        cfg(2, 20);
        run(lat, it);
        compared++;
        if (it !== 16'd2) begin mismatched++; $display("FAIL prec_two_limbs got %0d want 2", it); end
        cfg(1, 20);
        run(lat, it);
        compared++;
        if (it !== 16'd3) begin mismatched++; $display("FAIL prec_one_limb got %0d want 3", it); end
        compared++;
        if (lat !== 4) begin mismatched++; $display("FAIL prec_one_limb_latency got %0d want 4", lat); end
        cfg(0, 20);
        run(lat, it);
        compared++;
        if (it !== 16'd3) begin mismatched++; $display("FAIL prec_zero_limbs got %0d want 3", it); end
    endtask

    task automatic test_ignore_in_iter();
        int lat; logic [15:0] it;
        cfg(2, 10);
        wr_c(0, 8'h00, 8'h00);
        wr_c(1, 8'h00, 8'h00);
        kick();
        @(negedge clock);
        wr_index = 6'd0; real_data = 8'h01; imag_data = 8'h01;
        wr_real_en = 1'b1; wr_imag_en = 1'b1;
        num_limbs_data = 6'd1; iter_lim_data = 16'd3;
        wr_num_limbs_en = 1'b1; wr_iter_lim_en = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        wr_real_en = 1'b0; wr_imag_en = 1'b0;
        wr_num_limbs_en = 1'b0; wr_iter_lim_en = 1'b0; start = 1'b0;
        lat = 1;
        wait_ready(lat);
        compared++;
        if (lat !== 11) begin mismatched++; $display("FAIL ignore_latency got %0d want 11", lat); end
        compared++;
        if (iterations !== 16'd10) begin mismatched++; $display("FAIL ignore_iterations got %0d want 10", iterations); end
        run(lat, it);
        compared++;
        if (it !== 16'd10) begin mismatched++; $display("FAIL ignore_rerun got %0d want 10", it); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [15:0] it;
        kick();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        compared++;
        if (out_ready !== 1'b0) begin mismatched++; $display("FAIL midreset_out_ready got %b want 0", out_ready); end
        compared++;
        if (iterations !== 16'd0) begin mismatched++; $display("FAIL midreset_iterations got %0d want 0", iterations); end
        run(lat, it);
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL midreset_defaults_latency got %0d want 1", lat); end
    endtask

    initial begin
        test_reset();
        test_iter_zero();
        test_basic();
        test_back_to_back();
        test_zero_c();
        test_bounded();
        test_precision();
        test_ignore_in_iter();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
